// File: rtl/pc_lut_pkg.sv
// Shared constants for the loadable branch-target table: default widths,
// stream END marker and FSM state encodings.
package pc_lut_pkg;

   localparam int D_DEFAULT = 12;
   localparam int A_DEFAULT = 5;

   localparam logic [7:0] END_MARKER = 8'hFF;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE    = 3'd0;
   localparam state_t ST_GET_IDX = 3'd1;
   localparam state_t ST_GET_HI  = 3'd2;
   localparam state_t ST_GET_LO  = 3'd3;
   localparam state_t ST_WRITE   = 3'd4;
   localparam state_t ST_DONE    = 3'd5;
   localparam state_t ST_GET_CHK = 3'd6;

endpackage

// File: rtl/pc_lut_ram.sv
// Flop-based DEPTH x D target table: synchronous clear, one write port and a
// registered read port (read-before-write, out-of-range index reads 0).
module pc_lut_ram
   import pc_lut_pkg::*;
#(
   parameter int D = D_DEFAULT,
   parameter int A = A_DEFAULT
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         clr,
   input  logic         we,
   input  logic [A-1:0] waddr,
   input  logic [D-1:0] wdata,
   input  logic [7:0]   raddr,
   output logic [D-1:0] rdata
);

   localparam int DEPTH = 1 << A;

   logic [D-1:0] mem [DEPTH];
   logic         rd_ok;

   assign rd_ok = (int'(raddr) < DEPTH);

   // NOTE: the table is a flop array, so it may carry an async reset; a real
   // RAM macro could not be reset this way and would need a clear sequence.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         rdata <= '0;
      end else begin
         if (clr) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         end else if (we) begin
            mem[waddr] <= wdata;
         end
         // NOTE: non-blocking reads see the pre-edge array, which is exactly
         // the read-before-write (and read-before-clear) behaviour fetch expects.
         rdata <= rd_ok ? mem[raddr[A-1:0]] : '0;
      end
   end

endmodule

// File: rtl/pc_lut_loader.sv
// Byte-stream loader for the branch-target table: (idx, hi, lo) entries until
// an END marker. Optional checksum byte after END with PC_LUT_LOADER_CHECKSUM_EN.
module pc_lut_loader
   import pc_lut_pkg::*;
#(
   parameter int D = D_DEFAULT,
   parameter int A = A_DEFAULT
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         start,
   input  logic         s_valid,
   input  logic [7:0]   s_data,
   output logic         s_ready,
   input  logic [7:0]   lut_addr,
   output logic [D-1:0] lut_target,
   output logic         busy,
   output logic         done,
   output logic         err
);

   localparam int DEPTH = 1 << A;

   state_t       state;
   logic [7:0]   idx;
   logic [D-9:0] hi;
   logic [7:0]   lo;
   logic         err_q;
   logic         xfer;
   logic         idx_ok;
   logic         hi_ovf;
   logic         we;
`ifdef PC_LUT_LOADER_CHECKSUM_EN
   logic [7:0]   chk;
`endif

   always_comb begin
      s_ready = 1'b0;
      case (state)
         ST_GET_IDX, ST_GET_HI, ST_GET_LO: s_ready = 1'b1;
`ifdef PC_LUT_LOADER_CHECKSUM_EN
         ST_GET_CHK:                       s_ready = 1'b1;
`endif
         default:                          s_ready = 1'b0;
      endcase
   end

   assign xfer   = s_valid && s_ready;
   assign idx_ok = (int'(idx) < DEPTH);
   // Any bit of the high byte that does not fit into the D-8 upper target bits.
   assign hi_ovf = |(s_data >> (D - 8));
   // A restart in the WRITE cycle wins: the table is cleared, nothing written.
   assign we     = (state == ST_WRITE) && idx_ok && !start;

   assign busy = (state != ST_IDLE) && (state != ST_DONE);
   assign done = (state == ST_DONE);
   assign err  = err_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= ST_IDLE;
         idx   <= '0;
         hi    <= '0;
         lo    <= '0;
         err_q <= 1'b0;
`ifdef PC_LUT_LOADER_CHECKSUM_EN
         chk   <= '0;
`endif
      end else if (start) begin
         state <= ST_GET_IDX;
         err_q <= 1'b0;
`ifdef PC_LUT_LOADER_CHECKSUM_EN
         chk   <= '0;
`endif
      end else begin
         case (state)
            ST_GET_IDX: if (xfer) begin
               if (s_data == END_MARKER) begin
`ifdef PC_LUT_LOADER_CHECKSUM_EN
                  state <= ST_GET_CHK;
`else
                  state <= ST_DONE;
`endif
               end else begin
                  idx   <= s_data;
                  state <= ST_GET_HI;
`ifdef PC_LUT_LOADER_CHECKSUM_EN
                  chk   <= chk ^ s_data;
`endif
               end
            end
            ST_GET_HI: if (xfer) begin
               hi    <= s_data[D-9:0];
               if (hi_ovf) err_q <= 1'b1;
               state <= ST_GET_LO;
`ifdef PC_LUT_LOADER_CHECKSUM_EN
               chk   <= chk ^ s_data;
`endif
            end
            ST_GET_LO: if (xfer) begin
               lo    <= s_data;
               state <= ST_WRITE;
`ifdef PC_LUT_LOADER_CHECKSUM_EN
               chk   <= chk ^ s_data;
`endif
            end
            ST_WRITE: begin
               if (!idx_ok) err_q <= 1'b1;
               state <= ST_GET_IDX;
            end
`ifdef PC_LUT_LOADER_CHECKSUM_EN
            ST_GET_CHK: if (xfer) begin
               if (s_data != chk) err_q <= 1'b1;
               state <= ST_DONE;
            end
`endif
            default: ;
         endcase
      end
   end

   pc_lut_ram #(.D(D), .A(A)) u_ram (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (start),
      .we      (we),
      .waddr   (idx[A-1:0]),
      .wdata   ({hi, lo}),
      .raddr   (lut_addr),
      .rdata   (lut_target)
   );

endmodule
